// File: rtl/sprite_linebuf_ctrl.sv
// sprite_linebuf_ctrl: sequences a ping-pong sprite line buffer; display read/clear has 3-cycle latency.
// `define LINEBUF_PRIORITY_EN for first-drawn-wins RMW (spr_ready drops per opaque pixel); otherwise last-write-wins at 1/cycle.
`timescale 1ns/1ps
module sprite_linebuf_ctrl #(
  parameter int XW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          line_start,
  input  logic [XW-1:0] hpos,
  input  logic          disp_en,
  output logic [10:0]   pix_out,
  output logic          pix_valid,
  input  logic          spr_valid,
  output logic          spr_ready,
  input  logic [XW-1:0] spr_x,
  input  logic [10:0]   spr_dat,
  output logic [XW:0]   radr,
  output logic          clre,
  input  logic [10:0]   rdat,
  output logic [XW:0]   wadr,
  output logic [10:0]   wdat,
  output logic          we,
  input  logic [10:0]   rdat1,
  output logic          bank
);

  logic          bank_q, bank_d;
  logic [XW:0]   radr_q, radr_d;
  logic          clre_q, clre_d;
  logic          rd_vld_q, rd_vld_d;
  logic [10:0]   pix_out_q, pix_out_d;
  logic          pix_valid_q, pix_valid_d;
  logic [XW:0]   wadr_q, wadr_d;
  logic [10:0]   wdat_q, wdat_d;
  logic          we_q, we_d;
  logic          ready_c;
  logic          opaque;

  assign opaque = (spr_dat[3:0] != 4'd0);

  // Display side always reads the bank the renderer is not drawing into.
  always_comb begin
    bank_d      = bank_q ^ line_start;
    radr_d      = {~bank_q, hpos};
    clre_d      = disp_en;
    rd_vld_d    = clre_q;
    pix_valid_d = rd_vld_q;
    pix_out_d   = rd_vld_q ? rdat : 11'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q      <= 1'b0;
      radr_q      <= '0;
      clre_q      <= 1'b0;
      rd_vld_q    <= 1'b0;
      pix_out_q   <= 11'd0;
      pix_valid_q <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      radr_q      <= radr_d;
      clre_q      <= clre_d;
      rd_vld_q    <= rd_vld_d;
      pix_out_q   <= pix_out_d;
      pix_valid_q <= pix_valid_d;
    end
  end

`ifdef LINEBUF_PRIORITY_EN
  typedef enum logic [1:0] {IDLE, RD, CHK, WR} state_t;
  state_t     state_q, state_d;
  logic [6:0] rdat1_hi_unused;

  assign rdat1_hi_unused = rdat1[10:4];

  // wadr_q holds the latched {bank, x} for the whole RMW, so a bank swap mid-op is harmless.
  always_comb begin
    state_d = state_q;
    wadr_d  = wadr_q;
    wdat_d  = wdat_q;
    we_d    = 1'b0;
    ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = ~reset;
        if (spr_valid && ready_c && opaque) begin
          wadr_d  = {bank_q, spr_x};
          wdat_d  = spr_dat;
          state_d = RD;
        end
      end
      RD: state_d = CHK;
      CHK: begin
        if (rdat1[3:0] == 4'd0) begin
          we_d    = 1'b1;
          state_d = WR;
        end else begin
          state_d = IDLE;
        end
      end
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end
`else
  logic [10:0] rdat1_unused;

  assign rdat1_unused = rdat1;

  always_comb begin
    wadr_d  = wadr_q;
    wdat_d  = wdat_q;
    we_d    = 1'b0;
    ready_c = ~reset;
    if (spr_valid && ready_c && opaque) begin
      we_d   = 1'b1;
      wadr_d = {bank_q, spr_x};
      wdat_d = spr_dat;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wadr_q <= '0;
      wdat_q <= 11'd0;
      we_q   <= 1'b0;
    end else begin
      wadr_q <= wadr_d;
      wdat_q <= wdat_d;
      we_q   <= we_d;
    end
  end

  assign spr_ready = ready_c;
  assign pix_out   = pix_out_q;
  assign pix_valid = pix_valid_q;
  assign radr      = radr_q;
  assign clre      = clre_q;
  assign wadr      = wadr_q;
  assign wdat      = wdat_q;
  assign we        = we_q;
  assign bank      = bank_q;

endmodule

// File: tb/tb_sprite_linebuf_ctrl.sv
// Bench for sprite_linebuf_ctrl: RAM model, picture-level reference model, directed tests and random lines.
`timescale 1ns/1ps
module tb_sprite_linebuf_ctrl;

`ifdef LINEBUF_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk, reset, line_start, disp_en, spr_valid;
  logic [8:0]  hpos, spr_x;
  logic [10:0] spr_dat, pix_out, rdat, rdat1, wdat;
  logic        pix_valid, spr_ready, clre, we, bank;
  logic [9:0]  radr, wadr;

  sprite_linebuf_ctrl #(.XW(9)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .hpos(hpos), .disp_en(disp_en),
    .pix_out(pix_out), .pix_valid(pix_valid), .spr_valid(spr_valid), .spr_ready(spr_ready),
    .spr_x(spr_x), .spr_dat(spr_dat), .radr(radr), .clre(clre), .rdat(rdat),
    .wadr(wadr), .wdat(wdat), .we(we), .rdat1(rdat1), .bank(bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Line-buffer RAM: read-first, clear-on-read on the read port.
  logic [10:0] mem [0:1023];
  always @(posedge clk) begin
    rdat  <= mem[radr];
    rdat1 <= mem[wadr];
    if (clre) mem[radr] <= 11'd0;
    if (we)   mem[wadr] <= wdat;
  end

  // Reference model: picture contents per {bank,x}, plus timing rules from the block description.
  logic [10:0] img [0:1023];
  logic        m_bank, m_we, m_clre, rdy_prev;
  logic [9:0]  m_wadr, m_radr, ma;
  logic [10:0] m_wdat, dd0, dd1, dd2;
  logic        dv0, dv1, dv2;
  int          busy, we_in;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 11'd0;
      img[i] = 11'd0;
    end
    rdat = 11'd0; rdat1 = 11'd0;
    m_bank = 0; m_we = 0; m_clre = 0; m_wadr = 0; m_radr = 0; m_wdat = 0;
    dd0 = 0; dd1 = 0; dd2 = 0; dv0 = 0; dv1 = 0; dv2 = 0; busy = 0; we_in = 0;
  end

  always @(posedge clk) begin
    cyc++;
    if (m_we) img[m_wadr] = m_wdat;
    if (reset) begin
      m_bank = 0; busy = 0; we_in = 0; m_we = 0; m_clre = 0; m_radr = 0;
      m_wadr = 0; m_wdat = 0;
      dv0 = 0; dv1 = 0; dv2 = 0;
    end else begin
      rdy_prev = (busy == 0);
      if (busy > 0) busy--;
      m_we = 1'b0;
      if (we_in > 0) begin
        we_in--;
        if (we_in == 0) m_we = 1'b1;
      end
      dv2 = dv1; dd2 = dd1; dv1 = dv0; dd1 = dd0;
      dv0 = disp_en; m_clre = disp_en; m_radr = {~m_bank, hpos};
      if (disp_en) begin
        dd0 = img[m_radr];
        img[m_radr] = 11'd0;
      end
      if (spr_valid && rdy_prev && spr_dat[3:0] != 4'd0) begin
        ma = {m_bank, spr_x};
        m_wadr = ma; m_wdat = spr_dat;
        if (PRIO) begin
          if (img[ma][3:0] == 4'd0) begin busy = 3; we_in = 2; end
          else busy = 2;
        end else begin
          m_we = 1'b1;
        end
      end
      m_bank = m_bank ^ line_start;
    end
  end

  // Per-cycle compare plus monitors feeding the directed checks.
  logic [10:0] pq[$];
  int          pcyc[$];
  int          we_cnt = 0, clre_cnt = 0;
  logic [9:0]  last_wadr = 10'd0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("bank", 32'(bank), 32'(m_bank));
      chk("spr_ready", 32'(spr_ready), 32'((busy == 0) && !reset));
      chk("we", 32'(we), 32'(m_we));
      if (m_we) begin
        chk("wadr", 32'(wadr), 32'(m_wadr));
        chk("wdat", 32'(wdat), 32'(m_wdat));
      end
      chk("clre", 32'(clre), 32'(m_clre));
      if (m_clre) chk("radr", 32'(radr), 32'(m_radr));
      chk("pix_valid", 32'(pix_valid), 32'(dv2));
      if (dv2) chk("pix_out", 32'(pix_out), 32'(dd2));
      if (pix_valid) begin pq.push_back(pix_out); pcyc.push_back(cyc); end
      if (we) begin we_cnt++; last_wadr = wadr; end
      if (clre) clre_cnt++;
    end
  end

  function automatic logic [31:0] qget(input int i);
    return (i < pq.size()) ? 32'(pq[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic int cget(input int i);
    return (i < pcyc.size()) ? pcyc[i] : -1000;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [8:0] x, input logic [10:0] d, output int n);
    logic acc;
    n = 0;
    spr_x = x; spr_dat = d; spr_valid = 1'b1;
    do begin
      acc = spr_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    spr_valid = 1'b0;
    chk("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic pulse_line();
    line_start = 1'b1; @(posedge clk); #1; line_start = 1'b0;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      hpos = 9'(i); disp_en = 1'b1; @(posedge clk); #1;
    end
    disp_en = 1'b0;
  endtask

  task automatic rand_render(input int cnt);
    logic [10:0] d;
    int n;
    for (int k = 0; k < cnt; k++) begin
      idle(int'($urandom_range(0, 2)));
      d = 11'($urandom);
      if ($urandom_range(0, 3) == 0) d[3:0] = 4'd0;
      send(9'($urandom_range(0, 31)), d, n);
    end
  endtask

  task automatic rand_disp(input int n);
    for (int k = 0; k < n; k++) begin
      hpos = 9'($urandom_range(0, 31));
      disp_en = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    disp_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, tp, w0, c0, nz, bad;
    reset = 1'b1; line_start = 0; disp_en = 0; spr_valid = 0; hpos = 0; spr_x = 0; spr_dat = 0;
    @(posedge clk); #1;
    chk_on = 1'b1;
    idle(2);
    chk("rst_pix_out", 32'(pix_out), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_wadr", 32'(wadr), 0);
    chk("rst_wdat", 32'(wdat), 0);
    chk("rst_radr", 32'(radr), 0);
    chk("rst_spr_ready", 32'(spr_ready), 0);
    reset = 1'b0; #1;
    chk("rst_ready_after", 32'(spr_ready), 1);
    @(posedge clk); #1;

    // Draw then display one pixel; second read returns the cleared value.
    pq.delete(); pcyc.delete();
    send(9'd10, 11'h123, n);
    idle(5); pulse_line(); idle(6);
    hpos = 9'd10; disp_en = 1'b1; tp = cyc; @(posedge clk); #1;
    @(posedge clk); #1; disp_en = 1'b0;
    idle(5);
    chk("t1_count", 32'(pq.size()), 2);
    chk("t1_pix", qget(0), 32'h123);
    chk("t1_latency", 32'(cget(0) - tp), 3);
    chk("t1_reread", qget(1), 0);

    // Two writes to one x in a line.
    pq.delete(); pcyc.delete();
    send(9'd20, 11'h045, n);
    send(9'd20, 11'h0A7, n);
    idle(5); pulse_line(); idle(6);
    hpos = 9'd20; disp_en = 1'b1; @(posedge clk); #1; disp_en = 1'b0;
    idle(5);
    chk("t2_pix", qget(0), PRIO ? 32'h045 : 32'h0A7);

    // Transparent pixel: one-cycle accept, no write.
    w0 = we_cnt;
    send(9'd5, 11'h7F0, n);
    chk("t3_accept_cycles", 32'(n), 1);
    idle(4);
    chk("t3_no_write", 32'(we_cnt - w0), 0);
    chk("t3_ready", 32'(spr_ready), 1);

    // Bank swap right after accept: write lands in the old bank.
    pq.delete(); pcyc.delete();
    send(9'd30, 11'h3A5, n);
    pulse_line(); idle(6);
    chk("t4_wadr", 32'(last_wadr), 32'h01E);
    chk("t4_bank", 32'(bank), 1);
    hpos = 9'd30; disp_en = 1'b1; @(posedge clk); #1; disp_en = 1'b0;
    idle(5);
    chk("t4_pix", qget(0), 32'h3A5);

    // Reset during the read-back cycle.
    w0 = we_cnt;
    send(9'd40, 11'h011, n);
    reset = 1'b1; @(posedge clk); #1;
    chk("t5_we", 32'(we), 0);
    chk("t5_ready", 32'(spr_ready), 0);
    chk("t5_bank", 32'(bank), 0);
    chk("t5_clre", 32'(clre), 0);
    chk("t5_wadr", 32'(wadr), 0);
    idle(1);
    reset = 1'b0; #1;
    chk("t5_ready_after", 32'(spr_ready), 1);
    idle(5);
    chk("t5_writes", 32'(we_cnt - w0), PRIO ? 32'd0 : 32'd1);

    // Clear both banks, fill one with 11'h001, then stream it out twice.
    pulse_line(); idle(6); stream(512); idle(4);
    pulse_line(); idle(6); stream(512); idle(4);
    for (int i = 0; i < 512; i++) send(9'(i), 11'h001, n);
    idle(5); pulse_line(); idle(6);
    pq.delete(); pcyc.delete(); c0 = clre_cnt;
    stream(512); idle(5);
    bad = 0;
    for (int i = 0; i < pq.size(); i++) if (pq[i] != 11'h001) bad++;
    chk("t6_count", 32'(pq.size()), 512);
    chk("t6_values", 32'(bad), 0);
    chk("t6_consecutive", 32'(cget(511) - cget(0)), 511);
    chk("t6_clre_cycles", 32'(clre_cnt - c0), 512);
    pq.delete(); pcyc.delete();
    stream(512); idle(5);
    nz = 0;
    for (int i = 0; i < pq.size(); i++) if (pq[i] != 11'd0) nz++;
    chk("t6_reread_count", 32'(pq.size()), 512);
    chk("t6_reread_zero", 32'(nz), 0);

    // Random lines: render and display run concurrently on opposite banks.
    for (int ln = 0; ln < 10; ln++) begin
      fork
        rand_render(14);
        rand_disp(50);
      join
      idle(4); pulse_line(); idle(6);
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_linebuf_ctrl.md
# sprite_linebuf_ctrl

Sequencer for the double-banked sprite scanline buffer, a 1024 x 11-bit dual-port RAM with read-first ports and clear-on-read on the read port. Each line it ping-pongs two 512-pixel banks: the sprite renderer draws into the back bank through a priority read-modify-write port, while the video side reads and clears the front bank. It sits between the sprite engine, the line-buffer RAM and the colour mixer.

## Interface
- XW, 9, pixel x width; bank bit is address MSB, so RAM address width is XW+1.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- line_start  in  1  one-cycle pulse at start of hblank; swaps banks.
- hpos  in  XW  display pixel x.
- disp_en  in  1  hpos is an active pixel to read/clear.
- pix_out  out  11  buffered pixel to mixer.
- pix_valid  out  1  pix_out qualifies.
- spr_valid  in  1  renderer pixel request.
- spr_ready  out  1  request accepted when valid & ready.
- spr_x  in  XW  pixel x.
- spr_dat  in  11  pixel; bits [3:0] = pen, 0 = transparent.
- radr  out  XW+1  RAM read-port address {front bank, x}.
- clre  out  1  RAM read-port clear (writes 0 at radr).
- rdat  in  11  RAM read-port data.
- wadr  out  XW+1  RAM write-port address {back bank, x}.
- wdat  out  11  RAM write data.
- we  out  1  RAM write-port enable.
- rdat1  in  11  RAM write-port read-back data.
- bank  out  1  current back (draw) bank; front bank = ~bank.

## Operation
- RAM contract: address sampled on clk; data valid after the same edge; read-first, so a clear returns the old value.
- Bank swap: each line_start toggles bank. A request accepted before the swap keeps its latched bank and completes into the old bank.
- Display path: radr <= {~bank, hpos}; clre <= disp_en, both on one edge, so each shown pixel is zeroed for reuse two lines later. The rdat of a cleared read is registered into pix_out, and pix_valid is the disp_en delay matched to it.
- Render FSM, LINEBUF_PRIORITY_EN defined:
  - IDLE: spr_ready=1.
    - On accept with pen==0, drop the pixel and stay in IDLE.
    - On accept with pen!=0, latch spr_dat and {bank, spr_x}, drive wadr, go to RD.
  - RD: spr_ready=0, we=0; wait for RAM read-back. Go to CHK.
  - CHK: if rdat1[3:0]==0, set we=1 and wdat=latched data, go to WR. Otherwise discard, go to IDLE. The first-drawn sprite wins.
  - WR: we deasserted next edge; go to IDLE.
- Throughput is one opaque pixel per 4 cycles, or 3 if the pixel is discarded. Transparent pixels are accepted at 1 per cycle.
- The read and write ports always address opposite banks, so there are no address collisions.
- reset mid-RMW abandons the operation with no write. Buffer contents are not cleared by reset.

## Timing
- Reset values, held while reset=1: pix_out=0, pix_valid=0, bank=0, we=0, clre=0, radr=0, wadr=0, wdat=0, spr_ready=0, FSM=IDLE.
- spr_ready=1 from the first cycle after reset deasserts.
- Display latency: hpos/disp_en at edge N → radr/clre at N+1 → rdat valid after N+2 → pix_out/pix_valid registered at N+3. Latency is 3 cycles, fully pipelined.
- bank toggles on the edge sampling line_start, and radr/wadr use the new bank from the next request or pixel.
- Render: accept edge A → wadr valid A+1 → rdat1 valid after A+2 → we=1 during A+3 → RAM write at A+4 → spr_ready=1 again at A+4.
- line_start and accept in the same cycle: the request latches the pre-toggle bank.

## Configuration
- LINEBUF_PRIORITY_EN defined: read-modify-write priority FSM as above.
- LINEBUF_PRIORITY_EN undefined: no read-back and rdat1 is ignored. spr_ready=1 always, except during reset.
  - An opaque pixel written on accept edge A has we/wadr/wdat registered at A+1.
  - Last written wins.

## Test plan
- Accept spr_x=10, spr_dat=11'h123 on line 0, pulse line_start, then disp_en at hpos=10. Expected: pix_out=11'h123, pix_valid=1 three cycles later. A second read of x=10 returns 0.
- Write 11'h045 then 11'h0A7 to x=20 in the same line. Expected: pix_out=11'h045 (priority). With the macro undefined, pix_out=11'h0A7.
- spr_dat=11'h7F0 (pen 0) at x=5. Expected: accepted in 1 cycle, we never asserted, spr_ready stays 1.
- Pulse line_start the cycle after accepting x=30. Expected: write lands at wadr={old bank,30}; bank toggled; the pixel is displayed on the following line.
- Assert reset in RD state. Expected: no write; all outputs at reset values; spr_ready=1 the cycle after reset drops.
- Stream hpos 0..511 with disp_en=1 over a bank full of 11'h001. Expected: 512 consecutive valid outputs with pix_out=11'h001, clre high for 512 cycles; a re-read gives all zeros.
